// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 RX lane path: sequencer state encodings,
// LP line-state constants and the HS sync byte.
package csi_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STOP      = 3'd1,
        ST_HS_RQST   = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SYNC_WAIT = 3'd4,
        ST_HS_ACTIVE = 3'd5,
        ST_ERR_WAIT  = 3'd6
    } lane_state_e;

    // LP states written as {Dp, Dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP10 = 2'b10;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/csi_rx_lp_filter.sv
// Two-flop synchronizer plus glitch filter for a pair of asynchronous LP lines.
// Shared by the data-lane sequencer and the clock lane's ULPS detect.
module csi_rx_lp_filter #(
    parameter int unsigned LP_FILT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] lp_raw_i,
    output logic [1:0] lp_f_o
);

    logic [1:0] sync1_q, sync2_q;
    logic [1:0] prev_q;
    logic [3:0] held_q, held_d;
    logic [1:0] lp_f_q, lp_f_d;

    // held_d counts consecutive cycles, including this one, that the
    // synchronized value has stayed the same; it saturates so it never wraps.
    always_comb begin
        held_d = 4'd1;
        lp_f_d = lp_f_q;
        if (sync2_q == prev_q) begin
            held_d = (held_q == 4'hF) ? held_q : held_q + 4'd1;
        end
        if (held_d >= 4'(LP_FILT)) begin
            lp_f_d = sync2_q;
        end
    end

    // NOTE: state is written with <= only, so every flop samples pre-edge values.
    // The line idles at LP-11, so every stage resets to 11 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
            held_q  <= 4'd0;
            lp_f_q  <= 2'b11;
        end else begin
            sync1_q <= lp_raw_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            held_q  <= held_d;
            lp_f_q  <= lp_f_d;
        end
    end

    assign lp_f_o = lp_f_q;

endmodule

// File: rtl/csi_rx_lane_ctrl.sv
// D-PHY data-lane receive sequencer: walks LP-11/01/00, HS settle and sync search.
// Optional SoT error counter is enabled by defining CSI_RX_LANE_ERR_CNT_EN.
module csi_rx_lane_ctrl
    import csi_rx_pkg::*;
#(
    parameter int unsigned LP_FILT      = 2,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        CLK_BYTE,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        LP_P,
    input  logic        LP_N,
    input  logic        SYNC_DET,
    output logic        HS_TERM_EN,
    output logic        ALIGN_EN,
    output logic        LANE_ACTIVE,
    output logic        SOT_ERR,
    output logic        EOT,
    output logic [2:0]  STATE
`ifdef CSI_RX_LANE_ERR_CNT_EN
    ,
    input  logic        ERR_CLR,
    output logic [15:0] ERR_CNT
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SYNC_TIMEOUT - 1);

    logic [1:0]       lp_f;
    lane_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sot_err_d, eot_d;
    logic             term_q, align_q, active_q, sot_err_q, eot_q;

    csi_rx_lp_filter #(
        .LP_FILT (LP_FILT)
    ) u_lp_filter (
        .clk      (CLK_BYTE),
        .rst_n    (RST_N),
        .lp_raw_i ({LP_P, LP_N}),
        .lp_f_o   (lp_f)
    );

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        sot_err_d = 1'b0;
        eot_d     = 1'b0;
        if (!ENABLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_STOP;
                ST_STOP: begin
                    if (lp_f == LP01) state_d = ST_HS_RQST;
                end
                ST_HS_RQST: begin
                    if (lp_f == LP00) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (lp_f == LP11) begin
                        state_d = ST_STOP;
                    end else if (lp_f == LP10) begin
                        state_d   = ST_ERR_WAIT;
                        sot_err_d = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (lp_f == LP11) begin
                        state_d   = ST_STOP;
                        sot_err_d = 1'b1;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SYNC_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_SYNC_WAIT: begin
                    // A sync detect arriving on the timeout cycle still wins.
                    if (lp_f == LP11) begin
                        state_d   = ST_STOP;
                        sot_err_d = 1'b1;
                    end else if (SYNC_DET) begin
                        state_d = ST_HS_ACTIVE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d   = ST_ERR_WAIT;
                        sot_err_d = 1'b1;
                    end
                end
                ST_HS_ACTIVE: begin
                    if (lp_f == LP11) begin
                        state_d = ST_STOP;
                        eot_d   = 1'b1;
                    end
                end
                ST_ERR_WAIT: begin
                    if (lp_f == LP11) state_d = ST_STOP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Enables are decoded from the next state so they are valid on state entry.
    always_ff @(posedge CLK_BYTE or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            term_q    <= 1'b0;
            align_q   <= 1'b0;
            active_q  <= 1'b0;
            sot_err_q <= 1'b0;
            eot_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            term_q    <= (state_d == ST_SETTLE) || (state_d == ST_SYNC_WAIT) ||
                         (state_d == ST_HS_ACTIVE);
            align_q   <= (state_d == ST_SYNC_WAIT);
            active_q  <= (state_d == ST_HS_ACTIVE);
            sot_err_q <= sot_err_d;
            eot_q     <= eot_d;
        end
    end

    assign HS_TERM_EN  = term_q;
    assign ALIGN_EN    = align_q;
    assign LANE_ACTIVE = active_q;
    assign SOT_ERR     = sot_err_q;
    assign EOT         = eot_q;
    assign STATE       = state_q;

`ifdef CSI_RX_LANE_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge CLK_BYTE or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q <= 16'd0;
        end else if (ERR_CLR) begin
            err_cnt_q <= 16'd0;
        end else if (sot_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_csi_rx_lane_ctrl.sv
// Directed bench for csi_rx_lane_ctrl with a cycle-level reference model and
// per-cycle output comparison; error-counter checks run when CSI_RX_LANE_ERR_CNT_EN is defined.
module tb_csi_rx_lane_ctrl;

    localparam int LP_FILT      = 2;
    localparam int SETTLE_CYC   = 8;
    localparam int SYNC_TIMEOUT = 32;

    localparam int S_IDLE = 0, S_STOP = 1, S_RQST = 2, S_SETTLE = 3;
    localparam int S_SYNC = 4, S_ACTIVE = 5, S_ERR = 6;

    localparam int W_TERM = 0, W_ALIGN = 1, W_SOT = 2, W_EOT = 3, W_STOP = 4, W_RQST = 5;

    logic        CLK_BYTE = 1'b0;
    logic        RST_N    = 1'b0;
    logic        ENABLE   = 1'b0;
    logic        LP_P     = 1'b1;
    logic        LP_N     = 1'b1;
    logic        SYNC_DET = 1'b0;
    logic        err_clr  = 1'b0;
    logic        HS_TERM_EN, ALIGN_EN, LANE_ACTIVE, SOT_ERR, EOT;
    logic [2:0]  STATE;
    logic [15:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 CLK_BYTE = ~CLK_BYTE;

    csi_rx_lane_ctrl #(
        .LP_FILT      (LP_FILT),
        .SETTLE_CYC   (SETTLE_CYC),
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .CNT_W        (8)
    ) dut (
        .CLK_BYTE    (CLK_BYTE),
        .RST_N       (RST_N),
        .ENABLE      (ENABLE),
        .LP_P        (LP_P),
        .LP_N        (LP_N),
        .SYNC_DET    (SYNC_DET),
        .HS_TERM_EN  (HS_TERM_EN),
        .ALIGN_EN    (ALIGN_EN),
        .LANE_ACTIVE (LANE_ACTIVE),
        .SOT_ERR     (SOT_ERR),
        .EOT         (EOT),
        .STATE       (STATE)
`ifdef CSI_RX_LANE_ERR_CNT_EN
        ,
        .ERR_CLR     (err_clr),
        .ERR_CNT     (err_cnt)
`endif
    );

`ifndef CSI_RX_LANE_ERR_CNT_EN
    assign err_cnt = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pin history window for the filter, state + age for the sequence.
    logic [1:0] hist[$];
    int         m_state, m_age, m_errcnt;
    logic [1:0] m_lpf;
    bit         m_term, m_align, m_active, m_sot, m_eot;

    task automatic model_reset();
        hist.delete();
        repeat (LP_FILT + 4) hist.push_back(2'b11);
        m_state = S_IDLE; m_age = 0; m_lpf = 2'b11; m_errcnt = 0;
        m_term = 0; m_align = 0; m_active = 0; m_sot = 0; m_eot = 0;
    endtask

    task automatic model_step();
        int ns;
        bit sot, eot, stable;
        logic [1:0] cand;
        ns = m_state; sot = 0; eot = 0;
        if (!ENABLE) ns = S_IDLE;
        else case (m_state)
            S_IDLE:   ns = S_STOP;
            S_STOP:   if (m_lpf == 2'b01) ns = S_RQST;
            S_RQST:   if (m_lpf == 2'b00) ns = S_SETTLE;
                      else if (m_lpf == 2'b11) ns = S_STOP;
                      else if (m_lpf == 2'b10) begin ns = S_ERR; sot = 1; end
            S_SETTLE: if (m_lpf == 2'b11) begin ns = S_STOP; sot = 1; end
                      else if (m_age + 1 == SETTLE_CYC) ns = S_SYNC;
            S_SYNC:   if (m_lpf == 2'b11) begin ns = S_STOP; sot = 1; end
                      else if (SYNC_DET) ns = S_ACTIVE;
                      else if (m_age + 1 == SYNC_TIMEOUT) begin ns = S_ERR; sot = 1; end
            S_ACTIVE: if (m_lpf == 2'b11) begin ns = S_STOP; eot = 1; end
            S_ERR:    if (m_lpf == 2'b11) ns = S_STOP;
            default:  ns = S_IDLE;
        endcase
        m_age = (ns == m_state) ? m_age + 1 : 0;
        // Filter: accept the value sampled two edges ago once LP_FILT samples agree.
        cand = hist[hist.size() - 2];
        stable = 1;
        for (int k = 3; k <= LP_FILT + 1; k++)
            if (hist[hist.size() - k] != cand) stable = 0;
        if (stable) m_lpf = cand;
        hist.push_back({LP_P, LP_N});
        void'(hist.pop_front());
        m_state  = ns;
        m_term   = (ns == S_SETTLE) || (ns == S_SYNC) || (ns == S_ACTIVE);
        m_align  = (ns == S_SYNC);
        m_active = (ns == S_ACTIVE);
        m_sot    = sot;
        m_eot    = eot;
        if (err_clr) m_errcnt = 0;
        else if (sot && m_errcnt < 65535) m_errcnt++;
    endtask

    always @(posedge CLK_BYTE or negedge RST_N) begin
        if (!RST_N) model_reset();
        else model_step();
    end

    always @(negedge CLK_BYTE) begin
        if (cmp_en) begin
            check("cmp_state", 32'(STATE), 32'(m_state));
            check("cmp_term", 32'(HS_TERM_EN), 32'(m_term));
            check("cmp_align", 32'(ALIGN_EN), 32'(m_align));
            check("cmp_active", 32'(LANE_ACTIVE), 32'(m_active));
            check("cmp_sot_err", 32'(SOT_ERR), 32'(m_sot));
            check("cmp_eot", 32'(EOT), 32'(m_eot));
`ifdef CSI_RX_LANE_ERR_CNT_EN
            check("cmp_err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_BYTE);
    endtask

    task automatic set_lp(input logic [1:0] v);
        {LP_P, LP_N} = v;
    endtask

    function automatic bit hit(input int sel);
        case (sel)
            W_TERM:  return HS_TERM_EN;
            W_ALIGN: return ALIGN_EN;
            W_SOT:   return SOT_ERR;
            W_EOT:   return EOT;
            W_STOP:  return STATE == 3'd1;
            W_RQST:  return STATE == 3'd2;
            default: return 1'b0;
        endcase
    endfunction

    // Counts negedges until the selected condition holds, bounded by budget.
    task automatic wait_sig(input int sel, input int budget, output int n);
        n = 0;
        do begin
            @(negedge CLK_BYTE);
            n++;
        end while (!hit(sel) && n < budget);
        check("wait_hit", 32'(hit(sel)), 32'd1);
    endtask

    // SoT with no sync byte; optionally raises ERR_CLR on the timeout edge.
    task automatic run_timeout(input bit clr_on_err);
        int n;
        set_lp(2'b01); tick(6);
        set_lp(2'b00);
        wait_sig(W_ALIGN, 40, n);
        if (clr_on_err) begin
            tick(SYNC_TIMEOUT - 1);
            err_clr = 1'b1;
            tick(1);
            err_clr = 1'b0;
            check("timeout_clr_sot", 32'(SOT_ERR), 32'd1);
        end else begin
            wait_sig(W_SOT, 60, n);
            check("timeout_len", 32'(n), 32'd32);
        end
        check("timeout_state", 32'(STATE), 32'd6);
        set_lp(2'b11);
        wait_sig(W_STOP, 20, n);
        check("errwait_exit", 32'(n), 32'd5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tick(3);
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_term", 32'(HS_TERM_EN), 32'd0);
        check("rst_align", 32'(ALIGN_EN), 32'd0);
        check("rst_active", 32'(LANE_ACTIVE), 32'd0);
        check("rst_sot_err", 32'(SOT_ERR), 32'd0);
        check("rst_eot", 32'(EOT), 32'd0);
        RST_N  = 1'b1;
        cmp_en = 1'b1;
        tick(1);
        check("idle_disabled", 32'(STATE), 32'd0);
        ENABLE = 1'b1;
        tick(1);
        check("idle_to_stop", 32'(STATE), 32'd1);

        // Normal start of transmission and end on LP-11.
        set_lp(2'b01); tick(10);
        check("rqst_state", 32'(STATE), 32'd2);
        set_lp(2'b00);
        wait_sig(W_TERM, 40, n);
        check("settle_lat", 32'(n), 32'd5);
        check("model_settle_term", 32'(m_term), 32'd1);
        check("settle_state", 32'(STATE), 32'd3);
        wait_sig(W_ALIGN, 40, n);
        check("settle_len", 32'(n), 32'd8);
        check("sync_state", 32'(STATE), 32'd4);
        tick(4);
        SYNC_DET = 1'b1; tick(1); SYNC_DET = 1'b0;
        check("active_after_sync", 32'(LANE_ACTIVE), 32'd1);
        check("model_active_state", 32'(m_state), 32'd5);
        tick(3);
        set_lp(2'b11);
        wait_sig(W_EOT, 40, n);
        check("eot_lat", 32'(n), 32'd5);
        check("eot_state", 32'(STATE), 32'd1);
        check("eot_term_off", 32'(HS_TERM_EN), 32'd0);
        tick(1);
        check("eot_one_cycle", 32'(EOT), 32'd0);

        // Sync timeout.
        run_timeout(1'b0);

        // Glitch rejection, then a 3-cycle request aborted back to LP-11.
        set_lp(2'b01); tick(1); set_lp(2'b11); tick(8);
        check("glitch_reject", 32'(STATE), 32'd1);
        set_lp(2'b01); tick(3); set_lp(2'b11);
        wait_sig(W_RQST, 10, n);
        check("rqst_3cyc", 32'(n), 32'd2);
        wait_sig(W_STOP, 10, n);
        check("abort_stop", 32'(n), 32'd3);
        check("model_abort_no_err", 32'(m_sot), 32'd0);

        // LP-01 followed by LP-10 is a bad request.
        set_lp(2'b01); tick(6); set_lp(2'b10);
        wait_sig(W_SOT, 20, n);
        check("rqst_err_lat", 32'(n), 32'd5);
        check("rqst_err_state", 32'(STATE), 32'd6);
        set_lp(2'b11);
        wait_sig(W_STOP, 20, n);
        check("rqst_err_exit", 32'(n), 32'd5);

        // Disable in HS_ACTIVE on the same edge an EOT would have fired.
        set_lp(2'b01); tick(6); set_lp(2'b00);
        wait_sig(W_ALIGN, 40, n);
        tick(2);
        SYNC_DET = 1'b1; tick(1); SYNC_DET = 1'b0;
        tick(3);
        set_lp(2'b11); tick(4);
        check("pre_disable_active", 32'(STATE), 32'd5);
        ENABLE = 1'b0;
        tick(1);
        check("disable_state", 32'(STATE), 32'd0);
        check("disable_no_eot", 32'(EOT), 32'd0);
        check("disable_term", 32'(HS_TERM_EN), 32'd0);
        check("disable_active", 32'(LANE_ACTIVE), 32'd0);
        ENABLE = 1'b1;
        tick(1);
        check("reenable_stop", 32'(STATE), 32'd1);

        // Asynchronous reset in the middle of SETTLE.
        set_lp(2'b01); tick(6); set_lp(2'b00);
        wait_sig(W_TERM, 20, n);
        tick(3);
        @(posedge CLK_BYTE);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_async_term", 32'(HS_TERM_EN), 32'd0);
        check("rst_async_state", 32'(STATE), 32'd0);
        check("rst_async_align", 32'(ALIGN_EN), 32'd0);
        set_lp(2'b11);
        tick(2);
        RST_N = 1'b1;
        tick(2);
        check("post_rst_stop", 32'(STATE), 32'd1);

`ifdef CSI_RX_LANE_ERR_CNT_EN
        run_timeout(1'b0);
        run_timeout(1'b0);
        run_timeout(1'b0);
        check("err_cnt_three", 32'(err_cnt), 32'd3);
        run_timeout(1'b1);
        check("err_cnt_clr_wins", 32'(err_cnt), 32'd0);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csi_rx_lane_ctrl.md
Name: csi_rx_lane_ctrl

Overview:
- Per-data-lane D-PHY receive sequencer for the CSI-2 RX path, clocked by the byte clock from csi_rx_clk_phy.
- Watches the lane's LP line states and walks the start-of-transmission sequence: LP-11 → LP-01 → LP-00 → HS settle → sync word.
- Gates HS termination and the byte aligner, and flags the lane active for the packet layer.
- Returns the lane to stop state on LP-11 (EOT) and flags SoT errors.

Parameters:
- LP_FILT, 2: consecutive cycles a synchronized LP value must hold before it is accepted (1..15).
- SETTLE_CYC, 8: byte-clock cycles spent in SETTLE with termination on and aligner off (1..255).
- SYNC_TIMEOUT, 32: cycles allowed in SYNC_WAIT for the sync byte before an error (1..255).
- CNT_W, 8: width of the internal settle/timeout counter.

Ports:
- CLK_BYTE  in  1  byte clock; all logic is on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  lane enable; 0 forces IDLE.
- LP_P  in  1  raw LP receiver output, Dp (asynchronous).
- LP_N  in  1  raw LP receiver output, Dn (asynchronous).
- SYNC_DET  in  1  one-cycle pulse from the byte aligner when 0xB8 is found.
- HS_TERM_EN  out  1  HS termination/receiver enable.
- ALIGN_EN  out  1  byte aligner search enable.
- LANE_ACTIVE  out  1  aligned HS payload valid on the lane.
- SOT_ERR  out  1  one-cycle error pulse.
- EOT  out  1  one-cycle pulse when HS_ACTIVE ends on LP-11.
- STATE  out  3  current state encoding, for debug.

Behaviour:
- Reset: all outputs 0; STATE = IDLE (0). Filtered LP value resets to 2'b11, counters to 0. RST_N asserted mid-burst drops all outputs immediately, asynchronously.
- LP path: {LP_P, LP_N} passes through a 2-flop synchronizer, then a filter. The filtered value lp_f updates once the synchronized value has been equal for LP_FILT consecutive cycles. Pin-to-lp_f latency is 2+LP_FILT cycles; the FSM reacts on the following edge.
- State encodings: IDLE=0, STOP=1, HS_RQST=2, SETTLE=3, SYNC_WAIT=4, HS_ACTIVE=5, ERR_WAIT=6.
- IDLE: ENABLE=1 → STOP.
- STOP: lp_f==01 → HS_RQST. Other values hold STOP.
- HS_RQST:
  - lp_f==00 → SETTLE, counter cleared.
  - lp_f==11 → STOP with no error (aborted request).
  - lp_f==10 → ERR_WAIT with a SOT_ERR pulse.
- SETTLE: HS_TERM_EN=1. After exactly SETTLE_CYC cycles in the state → SYNC_WAIT, counter cleared.
- SYNC_WAIT: HS_TERM_EN=1, ALIGN_EN=1.
  - SYNC_DET → HS_ACTIVE.
  - Counter reaching SYNC_TIMEOUT without SYNC_DET → ERR_WAIT with a SOT_ERR pulse.
  - SYNC_DET on the timeout cycle wins: go to HS_ACTIVE, no error.
  - SYNC_DET in any other state is ignored.
- HS_ACTIVE: HS_TERM_EN=1, LANE_ACTIVE=1. lp_f==11 → STOP with an EOT pulse; LANE_ACTIVE and HS_TERM_EN fall on the same edge.
- ERR_WAIT: all enables 0. lp_f==11 → STOP.
- LP-11 in SETTLE or SYNC_WAIT → STOP with a SOT_ERR pulse.
- Output decode: HS_TERM_EN, ALIGN_EN and LANE_ACTIVE are registered decodes of the next state, so they are valid in the first cycle of each state.
- ENABLE=0 in any state → IDLE on the next edge with outputs 0. It has priority over every other transition and suppresses any EOT/SOT_ERR pulse on that edge.
- Counter saturates at its maximum; it never wraps.

Optional Feature:
- Macro: CSI_RX_LANE_ERR_CNT_EN.
- When defined:
  - Adds output ERR_CNT[15:0]: a count of SOT_ERR pulses that saturates at 16'hFFFF.
  - Adds input ERR_CLR (1 bit): synchronous clear that wins over a simultaneous increment.
  - ERR_CNT resets to 0.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Package csi_rx_pkg holds:
  - the state encodings;
  - LP constants LP11=2'b11, LP01=2'b01, LP00=2'b00, LP10=2'b10;
  - SYNC_BYTE=8'hB8.
- The natural sub-module is csi_rx_lp_filter: the 2-flop synchronizer plus the LP_FILT glitch filter. It is reused for the clock lane's ULPS detect.

Test Plan (all with default parameters):
- Normal SoT:
  - Stimulus: LP 11→01→00, each held 10 cycles; SYNC_DET pulsed 5 cycles into SYNC_WAIT.
  - Response: HS_TERM_EN rises 4 cycles after LP-00 plus 1; ALIGN_EN goes high exactly 8 cycles later; LANE_ACTIVE rises the cycle after SYNC_DET; LP-11 then gives one EOT pulse and STATE=1.
- Sync timeout:
  - Stimulus: SoT with no SYNC_DET.
  - Response: SOT_ERR pulses once 32 cycles after SYNC_WAIT entry; STATE=6 until LP-11, then 1.
- Glitch rejection:
  - Stimulus: in STOP, a 1-cycle LP 01 glitch.
  - Response: STATE stays 1. A 3-cycle 01 moves STATE to 2.
- Aborted request:
  - Stimulus: LP 11→01→11.
  - Response: STATE returns to 1, no SOT_ERR. A 01→10 sequence gives a SOT_ERR pulse and STATE=6.
- Disable and reset mid-burst:
  - Stimulus: ENABLE=0 in HS_ACTIVE; separately, RST_N low mid-SETTLE.
  - Response: ENABLE=0 gives all outputs 0 and STATE=0 next edge, no EOT; RST_N low gives all outputs 0 asynchronously.
- With CSI_RX_LANE_ERR_CNT_EN defined:
  - Stimulus: three timeouts.
  - Response: ERR_CNT=3; ERR_CLR coincident with a fourth error gives ERR_CNT=0.
